// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: fetch-side bundle (control, instruction memory, decode handshake)
interface fetch_ctrl_if;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_instr, if_ready,
    output imem_addr, if_valid, if_instr, if_pc
  );
  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_instr, if_ready,
    input  imem_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch with 2-entry buffer and redirect; FETCH_CTRL_PERF_EN adds perf counters
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, state_nxt;
  logic [31:0] pc, inflight_pc;
  logic        inflight, wr_ptr, rd_ptr, push, pop, issue;
  logic [1:0]  occ, pending;
  logic [31:0] buf_instr [FIFO_DEPTH];
  logic [31:0] buf_pc    [FIFO_DEPTH];
  assign bus.imem_addr = pc;
  assign bus.if_valid  = (occ != 2'd0) & ~bus.redirect_valid;
  assign bus.if_instr  = buf_instr[rd_ptr];
  assign bus.if_pc     = buf_pc[rd_ptr];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state and issue/push/pop decisions; buffer plus in-flight slot never exceeds two
  always_comb begin
    state_nxt = bus.fetch_en ? RUN : IDLE;
    pending   = occ + {1'b0, inflight};
    pop       = bus.if_valid & bus.if_ready;
    push      = inflight & ~bus.redirect_valid;
    issue     = (state == RUN) & ~bus.redirect_valid & ((pending < 2'd2) | ((pending == 2'd2) & pop));
  end
  // pc, in-flight tracking and buffer occupancy; redirect flushes everything
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'd0;
      occ         <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc       <= bus.redirect_pc & ~32'd3;
      inflight <= 1'b0;
      occ      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      if (issue) begin
        pc          <= pc + 32'd4;
        inflight_pc <= pc;
      end
      inflight <= issue;
      occ      <= occ + {1'b0, push} - {1'b0, pop};
      wr_ptr   <= wr_ptr ^ push;
      rd_ptr   <= rd_ptr ^ pop;
    end
  // buffer storage needs no reset: occupancy gates visibility
  always_ff @(posedge clk)
    if (push) begin
      buf_instr[wr_ptr] <= bus.imem_instr;
      buf_pc[wr_ptr]    <= inflight_pc;
    end
`ifdef FETCH_CTRL_PERF_EN
  // pop and stall counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      perf_fetched <= perf_fetched + {31'd0, pop};
      perf_stall   <= perf_stall + {31'd0, bus.if_valid & ~bus.if_ready};
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: random stimulus checked each cycle against a queue-based fetch model
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fetch_ctrl_if bus ();
  fetch_ctrl_if bus2 ();
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf2_fetched, perf2_stall;
  fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus), .perf_fetched(perf_fetched), .perf_stall(perf_stall));
  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .perf_fetched(perf2_fetched), .perf_stall(perf2_stall));
`else
  fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
`endif
  int checks = 0;
  int errors = 0;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  // instruction memory: one-cycle read latency
  always @(posedge clk) begin
    bus.imem_instr  <= mem(bus.imem_addr);
    bus2.imem_instr <= mem(bus2.imem_addr);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: buffered pcs in a queue, at most one outstanding fetch
  logic [31:0] q[$];
  logic [31:0] m_pc, m_ipc, m_fetched, m_stall;
  bit m_infl, m_run;
  always @(negedge clk) begin : cmp
    bit ev, pop, issue;
    int pend;
    if (!rst_n) begin
      q.delete();
      m_pc = 32'd0; m_infl = 0; m_run = 0; m_fetched = 0; m_stall = 0;
      chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("rst_imem_addr", bus.imem_addr, 32'd0);
    end else begin
      ev = q.size() != 0 && !bus.redirect_valid;
      chk("if_valid", {31'd0, bus.if_valid}, {31'd0, ev});
      chk("imem_addr", bus.imem_addr, m_pc);
      if (ev) begin
        chk("if_pc", bus.if_pc, q[0]);
        chk("if_instr", bus.if_instr, mem(q[0]));
      end
      pop = ev && bus.if_ready;
      pend = q.size() + int'(m_infl);
      issue = m_run && !bus.redirect_valid && (pend < 2 || (pend == 2 && pop));
      if (bus.redirect_valid) begin
        q.delete();
        m_infl = 0;
        m_pc = bus.redirect_pc & ~32'd3;
      end else begin
        if (pop) void'(q.pop_front());
        if (m_infl) q.push_back(m_ipc);
        if (issue) begin
          m_ipc = m_pc;
          m_pc = m_pc + 32'd4;
        end
        m_infl = issue;
      end
      m_run = bus.fetch_en;
    end
`ifdef FETCH_CTRL_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall", perf_stall, m_stall);
    if (rst_n) begin
      m_fetched = m_fetched + 32'(pop);
      m_stall = m_stall + 32'(ev && !bus.if_ready);
    end
`endif
  end
  initial begin
    bus.fetch_en = 1; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.if_ready = 1;
    bus2.fetch_en = 1; bus2.redirect_valid = 0; bus2.redirect_pc = 0; bus2.if_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("seq_valid", {31'd0, bus.if_valid}, 32'd1);
      chk("seq_pc", bus.if_pc, 32'(k * 4));
      chk("wrap_pc", bus2.if_pc, 32'hFFFF_FFF8 + 32'(k * 4));
    end
    @(posedge clk); #1 bus.if_ready = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stall_addr", bus.imem_addr, 32'h18);
    chk("stall_pc", bus.if_pc, 32'h10);
    @(posedge clk); #1 bus.redirect_valid = 1; bus.redirect_pc = 32'h43; bus.if_ready = 1;
    @(negedge clk); chk("redir_n0", {31'd0, bus.if_valid}, 32'd0);
    @(posedge clk); #1 bus.redirect_valid = 0;
    @(negedge clk); chk("redir_n1", {31'd0, bus.if_valid}, 32'd0);
    @(negedge clk); chk("redir_n2", {31'd0, bus.if_valid}, 32'd0);
    @(negedge clk);
    chk("redir_n3", {31'd0, bus.if_valid}, 32'd1);
    chk("redir_pc", bus.if_pc, 32'h40);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 15) == 0) bus.fetch_en = ~bus.fetch_en;
      bus.redirect_valid = $urandom_range(0, 19) == 0;
      bus.redirect_pc = $urandom;
      bus.if_ready = $urandom_range(0, 9) < 7;
    end
    @(posedge clk); #1 bus.fetch_en = 1; bus.redirect_valid = 0; bus.if_ready = 0;
    repeat (4) @(posedge clk);
    #2 chk("pre_rst_valid", {31'd0, bus.if_valid}, 32'd1);
    #1 rst_n = 0;
    #1 chk("async_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("async_addr", bus.imem_addr, 32'd0);
`ifdef FETCH_CTRL_PERF_EN
    chk("async_perf_fetched", perf_fetched, 32'd0);
    chk("async_perf_stall", perf_stall, 32'd0);
`endif
    @(posedge clk); #1 rst_n = 1; bus.if_ready = 1;
    @(posedge clk); #1 chk("restart_addr", bus.imem_addr, 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
